// File: rtl/flit_injector_if.sv
// Router-side four-phase link: injector drives data/req, router returns ack.
interface flit_injector_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data;
    logic              req;
    logic              ack;

    modport master (output data, output req, input ack);
    modport slave  (input data, input req, output ack);
endinterface

// File: rtl/flit_injector.sv
// Burst flit generator feeding one router input over a four-phase req/ack link.
// Define INJ_LFSR_EN to advance the payload as a 28-bit LFSR instead of a counter.
//
// state  | meaning
// IDLE   | waiting for start
// GAP    | counting idle cycles before the next flit (frozen while en is low)
// REQ    | out_req high, waiting for ack high
// REL    | out_req low, waiting for ack low
// DONE   | one-cycle done pulse
module flit_injector #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16,
    parameter logic [DATA_W-DEST_W-1:0] SEED = 28'h1929227
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                en_i,
    input  logic [DEST_W-1:0]   dest_i,
    input  logic [3:0]          gap_i,
    input  logic [CNT_W-1:0]    num_flits_i,
    flit_injector_if.master     rtr,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    sent_count_o
);
    localparam int PAY_W = DATA_W - DEST_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAP  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_REL  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

`ifdef INJ_LFSR_EN
    // An all-zero LFSR state would never leave zero.
    localparam logic [PAY_W-1:0] PAY_RST = (SEED == '0) ? PAY_W'(1) : SEED;
`else
    localparam logic [PAY_W-1:0] PAY_RST = SEED;
`endif

    logic [2:0]         state_q,   state_d;
    logic [DEST_W-1:0]  dest_q,    dest_d;
    logic [3:0]         gap_q,     gap_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   remain_q,  remain_d;
    logic [CNT_W-1:0]   sent_q,    sent_d;
    logic [PAY_W-1:0]   payload_q, payload_d;
    logic [DATA_W-1:0]  data_q,    data_d;
    logic               req_q,     req_d;
    logic [PAY_W-1:0]   payload_adv;

`ifdef INJ_LFSR_EN
    assign payload_adv = {payload_q[PAY_W-2:0], payload_q[PAY_W-1] ^ payload_q[PAY_W-4]};
`else
    assign payload_adv = payload_q + PAY_W'(1);
`endif

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        remain_d  = remain_q;
        sent_d    = sent_q;
        payload_d = payload_q;
        data_d    = data_q;
        req_d     = req_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    dest_d    = dest_i;
                    gap_d     = gap_i;
                    gap_cnt_d = gap_i;
                    remain_d  = num_flits_i;
                    state_d   = (num_flits_i == '0) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (en_i) begin
                    if (gap_cnt_q == 4'd0) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        data_d  = {dest_q, payload_q};
                    end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                    end
                end
            end
            S_REQ: begin
                if (rtr.ack) begin
                    req_d   = 1'b0;
                    state_d = S_REL;
                end
            end
            S_REL: begin
                if (!rtr.ack) begin
                    sent_d    = sent_q + CNT_W'(1);
                    payload_d = payload_adv;
                    remain_d  = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else if (gap_q == 4'd0 && en_i) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        data_d  = {dest_q, payload_adv};
                    end else begin
                        // The ack-low cycle already counts as the first idle cycle.
                        state_d   = S_GAP;
                        gap_cnt_d = (gap_q == 4'd0) ? 4'd0 : gap_q - 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            dest_q    <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            remain_q  <= '0;
            sent_q    <= '0;
            payload_q <= PAY_RST;
            data_q    <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            remain_q  <= remain_d;
            sent_q    <= sent_d;
            payload_q <= payload_d;
            data_q    <= data_d;
            req_q     <= req_d;
        end
    end

    assign rtr.data     = data_q;
    assign rtr.req      = req_q;
    assign busy_o       = (state_q == S_GAP) || (state_q == S_REQ) || (state_q == S_REL);
    assign done_o       = (state_q == S_DONE);
    assign sent_count_o = sent_q;
endmodule

// File: tb/tb_flit_injector.sv
// Self-checking bench for flit_injector with a one-cycle echo router model.
module tb_flit_injector;
    localparam logic [27:0] SEED = 28'h1929227;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  dest = '0;
    logic [3:0]  gap = '0;
    logic [15:0] num_flits = '0;
    logic        busy, done;
    logic [15:0] sent_count;
    logic        ack_hold = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    logic [27:0] payload_m;
    logic [15:0] sent_m;

    int          rise_cyc[$];
    logic [31:0] rise_data[$];
    int          done_cyc, req_high_cnt, data_bad, busy_bad;
    logic [15:0] sent_mid;

    flit_injector_if #(.DATA_W(32)) bus();

    flit_injector #(.DATA_W(32), .DEST_W(4), .CNT_W(16), .SEED(SEED)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .en_i         (en),
        .dest_i       (dest),
        .gap_i        (gap),
        .num_flits_i  (num_flits),
        .rtr          (bus),
        .busy_o       (busy),
        .done_o       (done),
        .sent_count_o (sent_count)
    );

    always #5 clk = ~clk;

    // Router: ack echoes req one cycle later unless held low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.ack <= 1'b0;
        else        bus.ack <= ack_hold ? 1'b0 : bus.req;
    end

    function automatic logic [27:0] pay_next(input logic [27:0] p);
`ifdef INJ_LFSR_EN
        return {p[26:0], p[27] ^ p[24]};
`else
        return p + 28'd1;
`endif
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        payload_m = SEED;
        sent_m = '0;
    endtask

    // Launches a burst and records what the link does, one sample per cycle after the start edge.
    task automatic run_burst(input logic [3:0] d, input logic [3:0] g, input logic [15:0] n,
                             input int en_off_at, input int en_off_len, input int hold_len,
                             input int extra_start_at, input int max_cyc);
        logic        prev_req;
        logic [31:0] prev_data;
        rise_cyc.delete();
        rise_data.delete();
        done_cyc = -1; req_high_cnt = 0; data_bad = 0; busy_bad = 0;
        sent_mid = sent_count;
        ack_hold = (hold_len > 0);
        @(negedge clk);
        dest = d; gap = g; num_flits = n; start = 1'b1;
        prev_req = bus.req;
        prev_data = bus.data;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= max_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            start = (c == extra_start_at);
            if (c == en_off_at) en = 1'b0;
            if (c == en_off_at + en_off_len) en = 1'b1;
            if (hold_len > 0 && rise_cyc.size() > 0 && c == rise_cyc[0] + hold_len) ack_hold = 1'b0;
            if (c == 20) sent_mid = sent_count;
            if (bus.req) req_high_cnt++;
            if (bus.req && !prev_req) begin
                rise_cyc.push_back(c);
                rise_data.push_back(bus.data);
            end else if (bus.data !== prev_data) begin
                data_bad++;
            end
            if (done) begin
                if (busy) busy_bad++;
                done_cyc = c;
                break;
            end
            if (!busy) busy_bad++;
            prev_req = bus.req;
            prev_data = bus.data;
        end
        start = 1'b0; en = 1'b1; ack_hold = 1'b0;
        @(posedge clk); #1;
        if (done_cyc < 0) apply_reset();
    endtask

    task automatic test_reset();
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.req); end
        n_checks++; if (bus.data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (sent_count !== 16'd0) begin n_fail++; $display("FAIL reset_sent: got %0d expected 0", sent_count); end
    endtask

    task automatic test_basic();
        int exp_c[3] = '{1, 5, 9};
        logic [27:0] p;
        p = payload_m;
        run_burst(4'h5, 4'h0, 16'd3, -1, 0, 0, -1, 60);
        n_checks++; if (rise_cyc.size() !== 3) begin n_fail++; $display("FAIL basic_nflits: got %0d expected 3", rise_cyc.size()); end
        for (int k = 0; k < 3 && k < rise_cyc.size(); k++) begin
            n_checks++; if (rise_cyc[k] !== exp_c[k]) begin n_fail++; $display("FAIL basic_rise%0d: got %0d expected %0d", k, rise_cyc[k], exp_c[k]); end
            n_checks++; if (rise_data[k] !== {4'h5, p}) begin n_fail++; $display("FAIL basic_data%0d: got %h expected %h", k, rise_data[k], {4'h5, p}); end
            p = pay_next(p);
        end
        payload_m = pay_next(pay_next(pay_next(payload_m)));
        sent_m = sent_m + 16'd3;
        n_checks++; if (done_cyc !== 13) begin n_fail++; $display("FAIL basic_done: got %0d expected 13", done_cyc); end
        n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL basic_sent: got %0d expected %0d", sent_count, sent_m); end
        n_checks++; if (data_bad !== 0 || busy_bad !== 0) begin n_fail++; $display("FAIL basic_stable: got data_bad=%0d busy_bad=%0d expected 0", data_bad, busy_bad); end
    endtask

    task automatic test_gap();
        run_burst(4'h9, 4'h3, 16'd2, -1, 0, 0, -1, 80);
        n_checks++; if (rise_cyc.size() !== 2) begin n_fail++; $display("FAIL gap_nflits: got %0d expected 2", rise_cyc.size()); end
        if (rise_cyc.size() == 2) begin
            n_checks++; if (rise_cyc[0] !== 4) begin n_fail++; $display("FAIL gap_first: got %0d expected 4", rise_cyc[0]); end
            n_checks++; if (rise_cyc[1] - rise_cyc[0] !== 7) begin n_fail++; $display("FAIL gap_period: got %0d expected 7", rise_cyc[1] - rise_cyc[0]); end
            n_checks++; if (rise_data[1] !== {4'h9, pay_next(payload_m)}) begin n_fail++; $display("FAIL gap_data1: got %h expected %h", rise_data[1], {4'h9, pay_next(payload_m)}); end
        end
        payload_m = pay_next(pay_next(payload_m));
        sent_m = sent_m + 16'd2;
        n_checks++; if (done_cyc !== 15) begin n_fail++; $display("FAIL gap_done: got %0d expected 15", done_cyc); end
        n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL gap_sent: got %0d expected %0d", sent_count, sent_m); end
    endtask

    task automatic test_ack_hold();
        logic [15:0] sent_before;
        sent_before = sent_m;
        run_burst(4'hC, 4'h0, 16'd1, -1, 0, 20, -1, 80);
        n_checks++; if (req_high_cnt !== 22) begin n_fail++; $display("FAIL hold_req_cycles: got %0d expected 22", req_high_cnt); end
        n_checks++; if (sent_mid !== sent_before) begin n_fail++; $display("FAIL hold_sent_mid: got %0d expected %0d", sent_mid, sent_before); end
        n_checks++; if (data_bad !== 0) begin n_fail++; $display("FAIL hold_data_stable: got %0d changes expected 0", data_bad); end
        n_checks++; if (done_cyc !== 25) begin n_fail++; $display("FAIL hold_done: got %0d expected 25", done_cyc); end
        payload_m = pay_next(payload_m);
        sent_m = sent_m + 16'd1;
        n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL hold_sent: got %0d expected %0d", sent_count, sent_m); end
    endtask

    task automatic test_en_pause();
        run_burst(4'h1, 4'h4, 16'd1, 1, 5, 0, -1, 80);
        n_checks++; if (rise_cyc.size() !== 1 || rise_cyc[0] !== 10) begin n_fail++; $display("FAIL en_gap_rise: got %0d flits first at %0d expected 1 at 10", rise_cyc.size(), (rise_cyc.size() > 0) ? rise_cyc[0] : -1); end
        n_checks++; if (done_cyc !== 14) begin n_fail++; $display("FAIL en_gap_done: got %0d expected 14", done_cyc); end
        payload_m = pay_next(payload_m);
        sent_m = sent_m + 16'd1;
        run_burst(4'h2, 4'h0, 16'd1, 1, 10, 0, -1, 80);
        n_checks++; if (done_cyc !== 5) begin n_fail++; $display("FAIL en_req_done: got %0d expected 5", done_cyc); end
        payload_m = pay_next(payload_m);
        sent_m = sent_m + 16'd1;
        n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL en_sent: got %0d expected %0d", sent_count, sent_m); end
    endtask

    task automatic test_zero_and_busy_start();
        run_burst(4'h7, 4'h2, 16'd0, -1, 0, 0, -1, 20);
        n_checks++; if (rise_cyc.size() !== 0) begin n_fail++; $display("FAIL zero_req: got %0d flits expected 0", rise_cyc.size()); end
        n_checks++; if (done_cyc !== 0) begin n_fail++; $display("FAIL zero_done: got %0d expected 0", done_cyc); end
        n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL zero_sent: got %0d expected %0d", sent_count, sent_m); end
        run_burst(4'h6, 4'h2, 16'd2, -1, 0, 0, 3, 80);
        n_checks++; if (rise_cyc.size() !== 2 || done_cyc !== 13) begin n_fail++; $display("FAIL busy_start: got %0d flits done %0d expected 2 done 13", rise_cyc.size(), done_cyc); end
        payload_m = pay_next(pay_next(payload_m));
        sent_m = sent_m + 16'd2;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || bus.req !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got busy=%b req=%b expected 0 0", busy, bus.req); end
        n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL busy_start_sent: got %0d expected %0d", sent_count, sent_m); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [3:0]  d, g;
            logic [15:0] n;
            logic [27:0] p;
            d = 4'($urandom_range(0, 15));
            g = 4'($urandom_range(0, 5));
            n = 16'($urandom_range(1, 4));
            p = payload_m;
            run_burst(d, g, n, -1, 0, 0, -1, 200);
            n_checks++; if (rise_cyc.size() !== int'(n)) begin n_fail++; $display("FAIL rand%0d_nflits: got %0d expected %0d", r, rise_cyc.size(), n); end
            for (int k = 0; k < int'(n) && k < rise_cyc.size(); k++) begin
                n_checks++; if (rise_cyc[k] !== int'(g) + 1 + k * (4 + int'(g))) begin n_fail++; $display("FAIL rand%0d_rise%0d: got %0d expected %0d", r, k, rise_cyc[k], int'(g) + 1 + k * (4 + int'(g))); end
                n_checks++; if (rise_data[k] !== {d, p}) begin n_fail++; $display("FAIL rand%0d_data%0d: got %h expected %h", r, k, rise_data[k], {d, p}); end
                p = pay_next(p);
            end
            for (int k = 0; k < int'(n); k++) payload_m = pay_next(payload_m);
            sent_m = sent_m + n;
            n_checks++; if (done_cyc !== int'(n) * (4 + int'(g)) + 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected %0d", r, done_cyc, int'(n) * (4 + int'(g)) + 1); end
            n_checks++; if (sent_count !== sent_m) begin n_fail++; $display("FAIL rand%0d_sent: got %0d expected %0d", r, sent_count, sent_m); end
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        @(negedge clk);
        dest = 4'hA; gap = 4'h0; num_flits = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (bus.req !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++; if (bus.req !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_req: got %b expected 1", bus.req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b expected 0", bus.req); end
        n_checks++; if (bus.data !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got data=%h busy=%b done=%b expected 0", bus.data, busy, done); end
        n_checks++; if (sent_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_sent: got %0d expected 0", sent_count); end
        @(negedge clk);
        rst_n = 1'b1;
        payload_m = SEED;
        sent_m = '0;
        run_burst(4'h3, 4'h1, 16'd2, -1, 0, 0, -1, 80);
        n_checks++; if (rise_cyc.size() !== 2) begin n_fail++; $display("FAIL rstmid_nflits: got %0d expected 2", rise_cyc.size()); end
        if (rise_cyc.size() == 2) begin
            n_checks++; if (rise_data[0] !== {4'h3, SEED}) begin n_fail++; $display("FAIL rstmid_data0: got %h expected %h", rise_data[0], {4'h3, SEED}); end
            n_checks++; if (rise_data[1] !== {4'h3, pay_next(SEED)}) begin n_fail++; $display("FAIL rstmid_data1: got %h expected %h", rise_data[1], {4'h3, pay_next(SEED)}); end
        end
        n_checks++; if (done_cyc !== 11 || sent_count !== 16'd2) begin n_fail++; $display("FAIL rstmid_done: got done %0d sent %0d expected 11 2", done_cyc, sent_count); end
    endtask

    initial begin
        payload_m = SEED;
        sent_m = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_gap();
        test_ack_hold();
        test_en_pause();
        test_zero_and_busy_start();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
